// File: rtl/mem64x8_arbiter.sv
// Two-requester arbiter and four-state access sequencer for a single-port 64x8 memory.
// Shares the array between the Wishbone slave port and a GPIO-side requester.
module mem64x8_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              io_req_i,
    input  logic              io_we_i,
    input  logic [ADDR_W-1:0] io_adr_i,
    input  logic [DATA_W-1:0] io_dat_i,
    output logic              io_ack_o,
    output logic [DATA_W-1:0] io_dat_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_dat_o,
    input  logic [DATA_W-1:0] mem_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic OWNER_WB = 1'b0;
    localparam logic OWNER_IO = 1'b1;

    state_t            state_r;
    state_t            state_s;
    logic              owner_r;
    logic              last_owner_r;
    logic              we_r;
    logic              sel0_r;
    logic [ADDR_W-1:0] adr_r;
    logic [DATA_W-1:0] dat_r;
    logic [DATA_W-1:0] rdata_r;
    logic              wb_req_s;
    logic              grant_s;
    logic              start_s;
    logic              unused_s;

    assign wb_req_s = wbs_cyc_i & wbs_stb_i;
    assign unused_s = ^{wbs_sel_i[3:1], wbs_adr_i[31:ADDR_W], wbs_dat_i[31:DATA_W]};

    // Grant selection and next-state sequencing.
    always_comb begin
        state_s = state_r;
        grant_s = OWNER_WB;
        start_s = 1'b0;
        // On a tie, the requester that was not served last wins.
        if (wb_req_s && io_req_i) begin
            grant_s = (last_owner_r == OWNER_WB) ? OWNER_IO : OWNER_WB;
        end else if (io_req_i) begin
            grant_s = OWNER_IO;
        end else begin
            grant_s = OWNER_WB;
        end
        case (state_r)
            ST_IDLE: begin
                if (wb_req_s || io_req_i) begin
                    state_s = ST_ACCESS;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS:  state_s = ST_CAPTURE;
            ST_CAPTURE: state_s = ST_RESP;
            ST_RESP:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch owner and transaction fields at grant time.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            owner_r      <= OWNER_WB;
            last_owner_r <= OWNER_IO;
            we_r         <= 1'b0;
            sel0_r       <= 1'b0;
            adr_r        <= {ADDR_W{1'b0}};
            dat_r        <= {DATA_W{1'b0}};
        end else if (start_s) begin
            owner_r      <= grant_s;
            last_owner_r <= grant_s;
            if (grant_s == OWNER_IO) begin
                we_r   <= io_we_i;
                sel0_r <= 1'b1;
                adr_r  <= io_adr_i;
                dat_r  <= io_dat_i;
            end else begin
                we_r   <= wbs_we_i;
                sel0_r <= wbs_sel_i[0];
                adr_r  <= wbs_adr_i[ADDR_W-1:0];
                dat_r  <= wbs_dat_i[DATA_W-1:0];
            end
        end
    end

    // Capture synchronous read data; writes leave it untouched.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_CAPTURE) && !we_r) begin
            rdata_r <= mem_dat_i;
        end
    end

    // Outputs decode directly from registers, so they are glitch-free.
    assign mem_en_o  = (state_r == ST_ACCESS);
    assign mem_we_o  = (state_r == ST_ACCESS) && we_r && sel0_r;
    assign mem_adr_o = adr_r;
    assign mem_dat_o = dat_r;
    assign wbs_ack_o = (state_r == ST_RESP) && (owner_r == OWNER_WB);
    assign io_ack_o  = (state_r == ST_RESP) && (owner_r == OWNER_IO);
    assign wbs_dat_o = {{(32-DATA_W){1'b0}}, rdata_r};
    assign io_dat_o  = rdata_r;

endmodule

// File: tb/tb_mem64x8_arbiter.sv
// Directed and randomized bench for mem64x8_arbiter with a behavioural memory model
// and transaction-level reference array.
module tb_mem64x8_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat_in;
    logic        wbs_ack;
    logic [31:0] wbs_dat_out;
    logic        io_req, io_we;
    logic [5:0]  io_adr;
    logic [7:0]  io_dat_in;
    logic        io_ack;
    logic [7:0]  io_dat_out;
    logic        mem_en, mem_we;
    logic [5:0]  mem_adr;
    logic [7:0]  mem_wdat;
    logic [7:0]  mem_rdat = 8'h00;

    logic [7:0]  macro_mem [64] = '{default: 8'h00};
    logic [7:0]  ref_mem   [64] = '{default: 8'h00};

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem64x8_arbiter dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (wbs_we),
        .wbs_sel_i(wbs_sel),
        .wbs_adr_i(wbs_adr),
        .wbs_dat_i(wbs_dat_in),
        .wbs_ack_o(wbs_ack),
        .wbs_dat_o(wbs_dat_out),
        .io_req_i (io_req),
        .io_we_i  (io_we),
        .io_adr_i (io_adr),
        .io_dat_i (io_dat_in),
        .io_ack_o (io_ack),
        .io_dat_o (io_dat_out),
        .mem_en_o (mem_en),
        .mem_we_o (mem_we),
        .mem_adr_o(mem_adr),
        .mem_dat_o(mem_wdat),
        .mem_dat_i(mem_rdat)
    );

    // Single-port synchronous-read memory macro.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) macro_mem[mem_adr] <= mem_wdat;
            mem_rdat <= macro_mem[mem_adr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction from one requester, starting at a negedge with the FSM idle.
    task automatic do_txn(input bit is_io, input bit we, input logic [31:0] adr,
                          input logic [7:0] dat, input logic [3:0] sel);
        int          n;
        int          we_cycles;
        int          other_acks;
        bit          got;
        bit          eff_wr;
        logic [5:0]  a;
        logic [31:0] r;
        logic [7:0]  exp_rd;
        a      = adr[5:0];
        eff_wr = we && (is_io || sel[0]);
        exp_rd = ref_mem[a];
        r      = $urandom();
        if (is_io) begin
            io_req = 1'b1; io_we = we; io_adr = a; io_dat_in = dat;
        end else begin
            cyc = 1'b1; stb = 1'b1; wbs_we = we; wbs_sel = sel;
            wbs_adr = adr; wbs_dat_in = {r[31:8], dat};
        end
        n = 0; got = 1'b0; we_cycles = 0; other_acks = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_we) begin
                we_cycles++;
                check("mem_wdat", mem_wdat, dat);
            end
            if (mem_en) check("mem_adr", mem_adr, a);
            if (is_io ? wbs_ack : io_ack) other_acks++;
            if (is_io ? io_ack : wbs_ack) got = 1'b1;
        end
        check(is_io ? "io_latency" : "wb_latency", n, 3);
        check("other_ack", other_acks, 0);
        check("mem_we_cycles", we_cycles, eff_wr ? 1 : 0);
        if (!we) begin
            if (is_io) check("io_rdata", io_dat_out, exp_rd);
            else       check("wb_rdata", wbs_dat_out, {24'h000000, exp_rd});
        end
        if (eff_wr) ref_mem[a] = dat;
        io_req = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check(is_io ? "io_ack_pulse" : "wb_ack_pulse", is_io ? io_ack : wbs_ack, 1'b0);
        if (!we) check("rdata_stable", io_dat_out, exp_rd);
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0;
        wbs_adr = 32'h0; wbs_dat_in = 32'h0;
        io_req = 1'b0; io_we = 1'b0; io_adr = 6'h00; io_dat_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_wb_ack", wbs_ack, 1'b0);
        check("rst_io_ack", io_ack, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_adr", mem_adr, 6'h00);
        check("rst_mem_dat", mem_wdat, 8'h00);
        check("rst_wb_dat", wbs_dat_out, 32'h0);
        check("rst_io_dat", io_dat_out, 8'h00);
        rst = 1'b0;

        // Tie from reset: WB first, then strict alternation while both hold.
        cyc = 1'b1; stb = 1'b1; wbs_we = 1'b0; wbs_sel = 4'hF; wbs_adr = 32'h0;
        io_req = 1'b1; io_we = 1'b0; io_adr = 6'd1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            check($sformatf("tie_wb_ack_c%0d", n), wbs_ack, (n == 3 || n == 11) ? 1'b1 : 1'b0);
            check($sformatf("tie_io_ack_c%0d", n), io_ack, (n == 7 || n == 15) ? 1'b1 : 1'b0);
        end
        cyc = 1'b0; stb = 1'b0; io_req = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 1'b1, 32'd5,  8'h2A, 4'hF);
        do_txn(1'b0, 1'b0, 32'd5,  8'h00, 4'hF);
        do_txn(1'b1, 1'b1, 32'd63, 8'hC3, 4'h0);
        do_txn(1'b1, 1'b0, 32'd63, 8'h00, 4'h0);
        do_txn(1'b0, 1'b1, 32'd7,  8'h00, 4'hF);
        do_txn(1'b0, 1'b1, 32'd7,  8'hFF, 4'b1110);
        do_txn(1'b0, 1'b0, 32'd7,  8'h00, 4'hF);
        do_txn(1'b1, 1'b1, 32'd5,  8'h11, 4'h0);
        do_txn(1'b0, 1'b0, 32'h45, 8'h00, 4'hF);

        // Reset during CAPTURE of a read: no ack, everything back to reset values.
        cyc = 1'b1; stb = 1'b1; wbs_we = 1'b0; wbs_sel = 4'hF; wbs_adr = 32'd63;
        repeat (2) @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("mid_rst_wb_ack", wbs_ack, 1'b0);
        check("mid_rst_io_ack", io_ack, 1'b0);
        check("mid_rst_mem_en", mem_en, 1'b0);
        check("mid_rst_mem_adr", mem_adr, 6'h00);
        check("mid_rst_mem_dat", mem_wdat, 8'h00);
        check("mid_rst_wb_dat", wbs_dat_out, 32'h0);
        check("mid_rst_io_dat", io_dat_out, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_access", mem_en, 1'b0);
        check("post_rst_no_ack", wbs_ack, 1'b0);
        do_txn(1'b0, 1'b0, 32'd63, 8'h00, 4'hF);

        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                   8'($urandom()), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem64x8_arbiter.md
# mem64x8_arbiter

Two-port arbiter and sequencer for the single-port 64x8 memory array in the user project area. It shares the array between the management SoC Wishbone slave port and a GPIO-side requester, runs a fixed four-state access sequence per transaction, and returns read data and a one-cycle acknowledge to whichever requester was granted. It sits between `user_project_wrapper` and the memory macro; the macro is never driven directly by either requester.

## Interface
- `ADDR_W`, 6, memory word address width (64 words)
- `DATA_W`, 8, memory word width
- `wb_clk_i`  in  1  sole clock; all state updates on rising edge
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `wbs_cyc_i`, `wbs_stb_i`  in  1 each  Wishbone cycle and strobe; a request is `cyc & stb`
- `wbs_we_i`  in  1  1 = write
- `wbs_sel_i`  in  4  byte selects; only bit 0 is used
- `wbs_adr_i`  in  32  bits [5:0] are the word address; bits [31:6] are ignored (aliased)
- `wbs_dat_i`  in  32  write data in bits [7:0]
- `wbs_ack_o`  out  1  one-cycle transaction acknowledge
- `wbs_dat_o`  out  32  `{24'h0, rdata_q}`
- `io_req_i`  in  1  GPIO-side request (level)
- `io_we_i`  in  1  1 = write
- `io_adr_i`  in  ADDR_W  word address
- `io_dat_i`  in  DATA_W  write data
- `io_ack_o`  out  1  one-cycle acknowledge
- `io_dat_o`  out  DATA_W  `rdata_q`
- `mem_en_o`, `mem_we_o`  out  1 each  memory enable / write enable
- `mem_adr_o`  out  ADDR_W  latched address
- `mem_dat_o`  out  DATA_W  latched write data
- `mem_dat_i`  in  DATA_W  read data, valid one cycle after the `mem_en_o` cycle (synchronous read)

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP. Reset state IDLE.
- IDLE: if any request is present, grant, latch owner/we/addr/wdata, go to ACCESS; otherwise stay.
- ACCESS: `mem_en_o=1`, `mem_we_o` = latched we (WB write also requires latched `sel[0]`); go to CAPTURE.
- CAPTURE: if read, `rdata_q <= mem_dat_i`; go to RESP.
- RESP: ack to the owner only (`wbs_ack_o` or `io_ack_o`), go to IDLE. Acks are decoded from the state register and the owner register.
- Arbitration: a lone requester wins. If both request in IDLE, grant the one that was not `last_owner`; update `last_owner` on every grant. Reset value of `last_owner` = IO, so WB wins the first tie.
- Requesters must drop their request in the cycle after they sample ack. A request still high in IDLE is treated as a new transaction.
- A WB write with `sel[0]=0` completes normally (acked) but `mem_we_o` stays 0; the memory is unchanged.
- Writes leave `rdata_q` unchanged.
- A request that arrives while the FSM is not in IDLE waits; it is not dropped.

## Timing
- Reset values: `wbs_ack_o=0`, `io_ack_o=0`, `mem_en_o=0`, `mem_we_o=0`, `mem_adr_o=0`, `mem_dat_o=0`, `rdata_q=0` (so `wbs_dat_o=0`, `io_dat_o=0`), state IDLE.
- Latency: a request first visible in IDLE at edge k gives ACCESS in cycle k+1, CAPTURE in k+2, and ack high for exactly cycle k+3. This applies to reads and writes alike.
- Throughput: one transaction per 4 cycles. Back-to-back transactions from alternating owners are granted on consecutive IDLE cycles.
- Read data is stable on `*_dat_o` from the ack cycle until the next read completes.
- Reset asserted mid-transaction: the state machine returns to IDLE at the next edge with no ack, and no memory access is issued after reset. A write already performed in ACCESS stays in memory. The requester reissues.
- Reset has priority over every other event in the same cycle.

## Test plan
- WB write `0x2A` to addr 5, then WB read addr 5 -> `wbs_ack_o` pulses 1 cycle, 3 cycles after each request; read returns `wbs_dat_o=32'h0000002A`; `io_ack_o` stays 0 throughout.
- IO write `0xC3` to addr 63, then IO read addr 63 -> `io_dat_o=8'hC3`; `io_ack_o` pulses once per transaction; `wbs_ack_o` stays 0.
- WB and IO both request from the same cycle after reset, each holding its request until acked -> WB is served first, then IO. With both held continuously thereafter, acks alternate WB/IO every 4 cycles.
- WB write `0xFF` to addr 7 with `sel=4'b1110`, then read addr 7 -> ack is given, `mem_we_o` never goes high, and the read returns the prior value (0 after an initialised write of 0).
- WB access at `wbs_adr_i=32'h45` after IO writes `0x11` to addr 5 -> the read returns `0x11` (aliasing on bits [5:0]).
- Assert `wb_rst_i` during CAPTURE of a read -> no ack, all outputs at reset values on the next cycle; a reissued read completes normally 3 cycles later.
